// File: rtl/dp_cr_pkg.sv
// -----------------------------------------------------------------------------
// dp_cr_pkg
// Shared types and constants for the DisplayPort clock-recovery sequencer:
//   cr_seq_state_t : Gray-coded 3-bit sequencer state
//   BW_* / LC_*    : link bandwidth and lane-count codes
//   TMR_W          : width of the sequencer timers
//   lane_mask()    : active-lane mask for a lane-count code
// No ports (package).
// -----------------------------------------------------------------------------
package dp_cr_pkg;

  // Gray sequence along the normal flow IDLE->APPLY->WAIT_INT->REQ_STS->EVAL
  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_APPLY    = 3'b001,
    ST_WAIT_INT = 3'b011,
    ST_REQ_STS  = 3'b010,
    ST_EVAL     = 3'b110,
    ST_WAIT_CHK = 3'b111,
    ST_PASS     = 3'b101,
    ST_FAIL     = 3'b100
  } cr_seq_state_t;

  localparam logic [7:0] BW_RBR  = 8'h06;
  localparam logic [7:0] BW_HBR  = 8'h0A;
  localparam logic [7:0] BW_HBR2 = 8'h14;
  localparam logic [7:0] BW_HBR3 = 8'h1E;

  localparam logic [1:0] LC_1 = 2'b00;
  localparam logic [1:0] LC_2 = 2'b01;
  localparam logic [1:0] LC_4 = 2'b11;

  localparam int TMR_W = 11;

  // The illegal code 2'b10 falls back to a single lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] lc);
    case (lc)
      LC_2:    lane_mask = 4'b0011;
      LC_4:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/cr_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// cr_seq_ctrl_if
// Bundles every non-clock signal of the CR sequencer.
//   master : the sequencer (cr_seq_ctrl)
//   slave  : its environment (LPM, AUX status reader, cr_err_chk, PHY)
// Groups: LPM config/start, status request/response, checker handshake and
// verdict flags, current drive/link settings, tps1_en/busy.
// -----------------------------------------------------------------------------
interface cr_seq_ctrl_if;
  logic       config_param_vld;
  logic [7:0] link_bw;
  logic [1:0] link_lc;
  logic       cr_start;
  logic       sts_req;
  logic       sts_vld;
  logic [3:0] lane_cr_done;
  logic [7:0] sink_adj_vtg;
  logic [7:0] sink_adj_pre;
  logic       cr_chk_start;
  logic [7:0] adj_vtg;
  logic [7:0] adj_pre;
  logic       cr_completed;
  logic       fsm_cr_failed;
  logic       drive_setting_flag;
  logic       bw_flag;
  logic       lc_flag;
  logic       err_cr_failed;
  logic [7:0] new_bw_cr;
  logic [1:0] new_lc_cr;
  logic [7:0] cur_vtg;
  logic [7:0] cur_pre;
  logic [7:0] cur_bw;
  logic [1:0] cur_lc;
  logic       tps1_en;
  logic       busy;

  modport master (
    input  config_param_vld, link_bw, link_lc, cr_start,
    input  sts_vld, lane_cr_done, sink_adj_vtg, sink_adj_pre,
    input  drive_setting_flag, bw_flag, lc_flag, err_cr_failed, new_bw_cr, new_lc_cr,
    output sts_req, cr_chk_start, adj_vtg, adj_pre, cr_completed, fsm_cr_failed,
    output cur_vtg, cur_pre, cur_bw, cur_lc, tps1_en, busy
  );

  modport slave (
    output config_param_vld, link_bw, link_lc, cr_start,
    output sts_vld, lane_cr_done, sink_adj_vtg, sink_adj_pre,
    output drive_setting_flag, bw_flag, lc_flag, err_cr_failed, new_bw_cr, new_lc_cr,
    input  sts_req, cr_chk_start, adj_vtg, adj_pre, cr_completed, fsm_cr_failed,
    input  cur_vtg, cur_pre, cur_bw, cur_lc, tps1_en, busy
  );
endinterface

// File: rtl/cr_seq_timer.sv
// -----------------------------------------------------------------------------
// cr_seq_timer
// Loadable down-counter that stops at zero (never wraps).
//   clk, rst    : clock, synchronous active-high reset (count -> 0)
//   i_load      : load i_load_val this cycle
//   i_load_val  : value to load
//   o_expired   : count is zero
// After a load of N the count reaches zero N cycles later, so a wait of
// N+1 cycles is obtained by loading N.
// -----------------------------------------------------------------------------
module cr_seq_timer
  import dp_cr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  output logic             o_expired
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/cr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cr_seq_ctrl
// Source-side DisplayPort clock-recovery sequencer: applies drive settings
// with TPS1, waits the AUX read interval, requests lane status, hands failed
// lanes to cr_err_chk and applies its verdict (new drive, lower bandwidth,
// fewer lanes, or give up).
//   clk, rst : clock, synchronous active-high reset
//   cr_if    : cr_seq_ctrl_if.master (LPM, status reader, checker, PHY side)
// Parameters: INTERVAL_CYC (settle wait), STS_TIMEOUT (status wait limit),
//             CHK_TIMEOUT (checker verdict wait limit), all in clock cycles.
// -----------------------------------------------------------------------------
module cr_seq_ctrl
  import dp_cr_pkg::*;
#(
  parameter int INTERVAL_CYC = 400,
  parameter int STS_TIMEOUT  = 1024,
  parameter int CHK_TIMEOUT  = 64
) (
  input  logic clk,
  input  logic rst,
  cr_seq_ctrl_if.master cr_if
);

  localparam logic [TMR_W-1:0] INT_LOAD = TMR_W'(INTERVAL_CYC - 1);
  localparam logic [TMR_W-1:0] STS_LOAD = TMR_W'(STS_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CHK_LOAD = TMR_W'(CHK_TIMEOUT - 1);

  cr_seq_state_t r_state, w_state_nxt;
  logic          r_tps1_en, w_tps1_nxt;
  logic [7:0]    r_cur_vtg, r_cur_pre, r_cur_bw;
  logic [7:0]    w_vtg_nxt, w_pre_nxt, w_bw_nxt;
  logic [1:0]    r_cur_lc, w_lc_nxt;
  logic [7:0]    r_adj_vtg, r_adj_pre;
  logic [3:0]    r_cr_done;
  logic          w_cap;
  logic          w_int_load, w_int_exp;
  logic          w_to_load, w_to_exp;
  logic [TMR_W-1:0] w_to_val;
  logic [3:0]    w_mask;
  logic          w_all_done;

  assign w_mask     = lane_mask(r_cur_lc);
  assign w_all_done = ((r_cr_done & w_mask) == w_mask);

  cr_seq_timer u_int_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_int_load),
    .i_load_val (INT_LOAD),
    .o_expired  (w_int_exp)
  );

  // Shared by the status wait and the checker wait; they never overlap.
  cr_seq_timer u_to_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_to_load),
    .i_load_val (w_to_val),
    .o_expired  (w_to_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tps1_en <= 1'b0;
      r_cur_vtg <= '0;
      r_cur_pre <= '0;
      r_cur_bw  <= '0;
      r_cur_lc  <= '0;
      r_adj_vtg <= '0;
      r_adj_pre <= '0;
      r_cr_done <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tps1_en <= w_tps1_nxt;
      r_cur_vtg <= w_vtg_nxt;
      r_cur_pre <= w_pre_nxt;
      r_cur_bw  <= w_bw_nxt;
      r_cur_lc  <= w_lc_nxt;
      if (w_cap) begin
        r_cr_done <= cr_if.lane_cr_done;
        r_adj_vtg <= cr_if.sink_adj_vtg;
        r_adj_pre <= cr_if.sink_adj_pre;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tps1_nxt  = r_tps1_en;
    w_vtg_nxt   = r_cur_vtg;
    w_pre_nxt   = r_cur_pre;
    w_bw_nxt    = r_cur_bw;
    w_lc_nxt    = r_cur_lc;
    w_cap       = 1'b0;
    w_int_load  = 1'b0;
    w_to_load   = 1'b0;
    w_to_val    = STS_LOAD;
    case (r_state)
      ST_IDLE: begin
        if (cr_if.config_param_vld) begin
          w_bw_nxt  = cr_if.link_bw;
          w_lc_nxt  = cr_if.link_lc;
          w_vtg_nxt = '0;
          w_pre_nxt = '0;
        end
        if (cr_if.cr_start) w_state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        w_tps1_nxt  = 1'b1;
        w_int_load  = 1'b1;
        w_state_nxt = ST_WAIT_INT;
      end
      ST_WAIT_INT: begin
        if (w_int_exp) begin
          w_to_load   = 1'b1;
          w_to_val    = STS_LOAD;
          w_state_nxt = ST_REQ_STS;
        end
      end
      ST_REQ_STS: begin
        // A status arriving on the last allowed cycle still counts.
        if (cr_if.sts_vld) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_EVAL;
        end else if (w_to_exp) begin
          w_state_nxt = ST_FAIL;
        end
      end
      ST_EVAL: begin
        if (w_all_done) begin
          w_state_nxt = ST_PASS;
        end else begin
          w_to_load   = 1'b1;
          w_to_val    = CHK_LOAD;
          w_state_nxt = ST_WAIT_CHK;
        end
      end
      ST_WAIT_CHK: begin
        if (cr_if.err_cr_failed) begin
          w_state_nxt = ST_FAIL;
        end else if (cr_if.bw_flag) begin
          // lc_flag is only meaningful together with bw_flag.
          w_bw_nxt    = cr_if.new_bw_cr;
          if (cr_if.lc_flag) w_lc_nxt = cr_if.new_lc_cr;
          w_vtg_nxt   = '0;
          w_pre_nxt   = '0;
          w_state_nxt = ST_APPLY;
        end else if (cr_if.drive_setting_flag) begin
          w_vtg_nxt   = r_adj_vtg;
          w_pre_nxt   = r_adj_pre;
          w_state_nxt = ST_APPLY;
        end else if (w_to_exp) begin
          w_state_nxt = ST_FAIL;
        end
      end
      ST_PASS: w_state_nxt = ST_IDLE;
      ST_FAIL: begin
        w_tps1_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign cr_if.sts_req       = (r_state == ST_REQ_STS);
  assign cr_if.cr_chk_start  = (r_state == ST_EVAL) && !w_all_done;
  assign cr_if.cr_completed  = (r_state == ST_PASS);
  assign cr_if.fsm_cr_failed = (r_state == ST_FAIL);
  assign cr_if.busy          = (r_state != ST_IDLE);
  assign cr_if.tps1_en       = r_tps1_en;
  assign cr_if.adj_vtg       = r_adj_vtg;
  assign cr_if.adj_pre       = r_adj_pre;
  assign cr_if.cur_vtg       = r_cur_vtg;
  assign cr_if.cur_pre       = r_cur_pre;
  assign cr_if.cur_bw        = r_cur_bw;
  assign cr_if.cur_lc        = r_cur_lc;

endmodule

// File: tb/tb_cr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cr_seq_ctrl
// Directed bench for cr_seq_ctrl with default timing parameters.
// -----------------------------------------------------------------------------
module tb_cr_seq_ctrl;
  import dp_cr_pkg::*;

  localparam int INTERVAL_CYC = 400;
  localparam int STS_TIMEOUT  = 1024;
  localparam int CHK_TIMEOUT  = 64;
  localparam int WAIT_LIMIT   = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  cr_seq_ctrl_if bus ();

  cr_seq_ctrl #(
    .INTERVAL_CYC (INTERVAL_CYC),
    .STS_TIMEOUT  (STS_TIMEOUT),
    .CHK_TIMEOUT  (CHK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cr_if (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic do_config(input logic [7:0] bw, input logic [1:0] lc);
    bus.config_param_vld = 1'b1;
    bus.link_bw = bw;
    bus.link_lc = lc;
    tick();
    bus.config_param_vld = 1'b0;
  endtask

  task automatic pulse_start();
    bus.cr_start = 1'b1;
    tick();
    bus.cr_start = 1'b0;
  endtask

  task automatic wait_sts(output int n);
    n = 0;
    while (bus.sts_req !== 1'b1 && n < WAIT_LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_fail(output int n);
    n = 0;
    while (bus.fsm_cr_failed !== 1'b1 && n < WAIT_LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic give_sts(input logic [3:0] done, input logic [7:0] vtg, input logic [7:0] pre);
    bus.sts_vld      = 1'b1;
    bus.lane_cr_done = done;
    bus.sink_adj_vtg = vtg;
    bus.sink_adj_pre = pre;
    tick();
    bus.sts_vld = 1'b0;
  endtask

  task automatic set_flags(input logic drv, input logic bw, input logic lc, input logic err,
                           input logic [7:0] nbw, input logic [1:0] nlc);
    bus.drive_setting_flag = drv;
    bus.bw_flag            = bw;
    bus.lc_flag            = lc;
    bus.err_cr_failed      = err;
    bus.new_bw_cr          = nbw;
    bus.new_lc_cr          = nlc;
  endtask

  initial begin
    int n;
    bus.config_param_vld = 1'b0;
    bus.link_bw          = '0;
    bus.link_lc          = '0;
    bus.cr_start         = 1'b0;
    bus.sts_vld          = 1'b0;
    bus.lane_cr_done     = '0;
    bus.sink_adj_vtg     = '0;
    bus.sink_adj_pre     = '0;
    set_flags(0, 0, 0, 0, 8'h00, 2'b00);

    // Reset state
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_sts_req", bus.sts_req, 0);
    chk("rst_tps1", bus.tps1_en, 0);
    chk("rst_cur_bw", bus.cur_bw, 0);
    chk("rst_cur_lc", bus.cur_lc, 0);
    chk("rst_outs", {bus.cr_chk_start, bus.cr_completed, bus.fsm_cr_failed}, 0);
    rst = 1'b0;
    tick();

    // 4-lane HBR3, all lanes done on first status
    do_config(BW_HBR3, LC_4);
    chk("cfg_bw", bus.cur_bw, 8'h1E);
    chk("cfg_lc", bus.cur_lc, 2'b11);
    pulse_start();
    chk("t1_busy", bus.busy, 1);
    wait_sts(n);
    chk("t1_sts_lat", n, INTERVAL_CYC + 1);
    chk("t1_tps1", bus.tps1_en, 1);
    give_sts(4'b1111, 8'h00, 8'h00);
    chk("t1_no_chk", bus.cr_chk_start, 0);
    tick();
    chk("t1_done", bus.cr_completed, 1);
    chk("t1_tps1_pass", bus.tps1_en, 1);
    tick();
    chk("t1_done_pulse", bus.cr_completed, 0);
    chk("t1_idle", bus.busy, 0);
    chk("t1_vtg", bus.cur_vtg, 0);

    // Drive adjust, then bandwidth reduction, then pass
    do_config(BW_HBR3, LC_4);
    pulse_start();
    wait_sts(n);
    give_sts(4'b0000, 8'h55, 8'hAA);
    chk("t2_chk_start", bus.cr_chk_start, 1);
    chk("t2_adj_vtg", bus.adj_vtg, 8'h55);
    chk("t2_adj_pre", bus.adj_pre, 8'hAA);
    tick();
    chk("t2_chk_pulse", bus.cr_chk_start, 0);
    set_flags(1, 0, 0, 0, 8'h00, 2'b00);
    tick();
    set_flags(0, 0, 0, 0, 8'h00, 2'b00);
    chk("t2_cur_vtg", bus.cur_vtg, 8'h55);
    chk("t2_cur_pre", bus.cur_pre, 8'hAA);
    wait_sts(n);
    chk("t2_sts2_lat", n, INTERVAL_CYC + 1);
    give_sts(4'b0000, 8'h11, 8'h22);
    tick();
    set_flags(0, 1, 0, 0, BW_HBR2, 2'b00);
    tick();
    set_flags(0, 0, 0, 0, 8'h00, 2'b00);
    chk("t2_bw", bus.cur_bw, 8'h14);
    chk("t2_lc_keep", bus.cur_lc, 2'b11);
    chk("t2_vtg0", bus.cur_vtg, 0);
    chk("t2_pre0", bus.cur_pre, 0);
    wait_sts(n);
    give_sts(4'b1111, 8'h00, 8'h00);
    tick();
    chk("t2_done", bus.cr_completed, 1);
    tick();

    // 2 lanes: upper lanes ignored; then bw+lc reduction to 1 lane
    do_config(BW_HBR, LC_2);
    pulse_start();
    wait_sts(n);
    give_sts(4'b0011, 8'h00, 8'h00);
    chk("t3_no_chk", bus.cr_chk_start, 0);
    tick();
    chk("t3_done", bus.cr_completed, 1);
    tick();
    pulse_start();
    wait_sts(n);
    give_sts(4'b0001, 8'h00, 8'h00);
    chk("t3_chk_start", bus.cr_chk_start, 1);
    tick();
    set_flags(0, 1, 1, 0, BW_HBR3, LC_1);
    tick();
    set_flags(0, 0, 0, 0, 8'h00, 2'b00);
    chk("t3_bw", bus.cur_bw, 8'h1E);
    chk("t3_lc", bus.cur_lc, 2'b00);
    wait_sts(n);
    give_sts(4'b0001, 8'h00, 8'h00);
    tick();
    chk("t3_done1", bus.cr_completed, 1);
    tick();

    // Flags outside WAIT_CHK ignored; err_cr_failed has top priority
    pulse_start();
    repeat (5) tick();
    set_flags(1, 1, 1, 1, BW_RBR, LC_4);
    repeat (3) tick();
    set_flags(0, 0, 0, 0, 8'h00, 2'b00);
    chk("t4_ign_bw", bus.cur_bw, 8'h1E);
    chk("t4_ign_busy", bus.busy, 1);
    chk("t4_ign_fail", bus.fsm_cr_failed, 0);
    wait_sts(n);
    give_sts(4'b0000, 8'h33, 8'h00);
    tick();
    set_flags(1, 0, 0, 1, 8'h00, 2'b00);
    tick();
    set_flags(0, 0, 0, 0, 8'h00, 2'b00);
    chk("t4_fail", bus.fsm_cr_failed, 1);
    chk("t4_vtg_keep", bus.cur_vtg, 0);
    tick();
    chk("t4_fail_pulse", bus.fsm_cr_failed, 0);
    chk("t4_tps1", bus.tps1_en, 0);
    chk("t4_idle", bus.busy, 0);

    // Checker timeout
    pulse_start();
    wait_sts(n);
    give_sts(4'b0000, 8'h00, 8'h00);
    wait_fail(n);
    chk("t5_chk_to", n, CHK_TIMEOUT + 1);
    tick();

    // Status timeout
    pulse_start();
    wait_sts(n);
    wait_fail(n);
    chk("t6_sts_to", n, STS_TIMEOUT);
    tick();

    // Status on the final allowed cycle wins over the timeout
    pulse_start();
    wait_sts(n);
    repeat (STS_TIMEOUT - 1) tick();
    chk("t7_still_req", bus.sts_req, 1);
    give_sts(4'b0001, 8'h00, 8'h00);
    chk("t7_no_fail", bus.fsm_cr_failed, 0);
    tick();
    chk("t7_done", bus.cr_completed, 1);
    tick();

    // Second cr_start while busy is ignored
    do_config(BW_HBR3, LC_4);
    pulse_start();
    repeat (10) tick();
    pulse_start();
    wait_sts(n);
    chk("t8_lat", n + 11, INTERVAL_CYC + 1);
    give_sts(4'b1111, 8'h00, 8'h00);
    tick();
    chk("t8_done", bus.cr_completed, 1);
    tick();

    // Reset during WAIT_INT
    pulse_start();
    repeat (50) tick();
    rst = 1'b1;
    tick();
    chk("t9_busy", bus.busy, 0);
    chk("t9_tps1", bus.tps1_en, 0);
    chk("t9_bw", bus.cur_bw, 0);
    chk("t9_flags", {bus.sts_req, bus.cr_completed, bus.fsm_cr_failed}, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("t9_stay_idle", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
